// File: rtl/multdiv_ctrl_pkg.sv
// Shared encodings and defaults for the multiply/divide issue controller.
package multdiv_ctrl_pkg;

    localparam int unsigned ALU_OP_W        = 5;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned OPC_W           = 5;
    localparam int unsigned DEFAULT_TIMEOUT = 40;
    localparam int unsigned DEFAULT_CNT_W   = 6;

    localparam logic [ALU_OP_W-1:0] ALU_OP_MUL = 5'b00110;
    localparam logic [ALU_OP_W-1:0] ALU_OP_DIV = 5'b00111;
    localparam logic [OPC_W-1:0]    OPC_RTYPE  = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    // True for the two ALU ops that are handed to the multdiv unit.
    function automatic logic is_md_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
    endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Counts BUSY cycles and flags the last cycle before a forced timeout.
module md_cycle_counter
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [CNT_W-1:0] count_q;

    // Cycle counter: synchronous clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Terminal count marks the final BUSY cycle the unit is allowed.
    assign tc_c = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/stall controller for the multi-cycle multiply/divide unit beside EX.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dx_valid,
    input  logic [ALU_OP_W-1:0] dx_alu_op,
    input  logic                dx_is_rtype,
    input  logic [REG_W-1:0]    dx_rd,
    input  logic                abort,
    input  logic                md_result_rdy,
    input  logic                md_exception,
    output logic                ctrl_mult,
    output logic                ctrl_div,
    output logic                stall,
    output logic                xm_bubble,
    output logic                xm_sel_md,
    output logic [REG_W-1:0]    md_wb_rd,
    output logic                md_exc
);

    md_state_e        state_q, state_d;
    logic             md_req_c;
    logic             cnt_clr;
    logic             cnt_en;
    logic             tc_c;
    logic [REG_W-1:0] md_wb_rd_d;
    logic             md_exc_d;

    // A live R-type mul/div in DX that is not being killed; held off during reset.
    assign md_req_c = rst_n & dx_valid & dx_is_rtype & is_md_op(dx_alu_op) & ~abort;

    md_cycle_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc_c  (tc_c)
    );

    // State and writeback-tag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            md_wb_rd <= '0;
            md_exc   <= 1'b0;
        end else begin
            state_q  <= state_d;
            md_wb_rd <= md_wb_rd_d;
            md_exc   <= md_exc_d;
        end
    end

    // Next-state, start pulses and stall; result-ready beats timeout in BUSY.
    always_comb begin
        state_d    = state_q;
        ctrl_mult  = 1'b0;
        ctrl_div   = 1'b0;
        stall      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        md_wb_rd_d = md_wb_rd;
        md_exc_d   = md_exc;
        unique case (state_q)
            ST_IDLE: begin
                if (md_req_c) begin
                    ctrl_mult  = (dx_alu_op == ALU_OP_MUL);
                    ctrl_div   = (dx_alu_op == ALU_OP_DIV);
                    stall      = 1'b1;
                    cnt_clr    = 1'b1;
                    md_wb_rd_d = dx_rd;
                    md_exc_d   = 1'b0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
                if (abort) begin
                    md_exc_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (md_result_rdy) begin
                    md_exc_d = md_exception;
                    state_d  = ST_DONE;
                end else if (tc_c) begin
                    md_exc_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign xm_bubble = stall;
    assign xm_sel_md = (state_q == ST_DONE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with hand-computed cycle expectations.
module tb_multdiv_ctrl;
    import multdiv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dx_valid;
    logic [4:0] dx_alu_op;
    logic       dx_is_rtype;
    logic [4:0] dx_rd;
    logic       abort;
    logic       md_result_rdy;
    logic       md_exception;
    logic       ctrl_mult;
    logic       ctrl_div;
    logic       stall;
    logic       xm_bubble;
    logic       xm_sel_md;
    logic [4:0] md_wb_rd;
    logic       md_exc;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dx_valid      (dx_valid),
        .dx_alu_op     (dx_alu_op),
        .dx_is_rtype   (dx_is_rtype),
        .dx_rd         (dx_rd),
        .abort         (abort),
        .md_result_rdy (md_result_rdy),
        .md_exception  (md_exception),
        .ctrl_mult     (ctrl_mult),
        .ctrl_div      (ctrl_div),
        .stall         (stall),
        .xm_bubble     (xm_bubble),
        .xm_sel_md     (xm_sel_md),
        .md_wb_rd      (md_wb_rd),
        .md_exc        (md_exc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Move into the next cycle window: just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        dx_valid = 1'b0; dx_is_rtype = 1'b0; dx_alu_op = 5'd0; dx_rd = 5'd0;
        abort = 1'b0; md_result_rdy = 1'b0; md_exception = 1'b0;
    endtask

    task automatic drive_op(input logic [4:0] op, input logic [4:0] rd);
        dx_valid = 1'b1; dx_is_rtype = 1'b1; dx_alu_op = op; dx_rd = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        drive_op(ALU_OP_MUL, 5'd7);
        #2;
        n_checks++; if (ctrl_mult !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl_mult: got %b expected 0", ctrl_mult); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b expected 0", stall); end
        n_checks++; if (xm_bubble !== 1'b0) begin n_fail++; $display("FAIL rst_xm_bubble: got %b expected 0", xm_bubble); end
        n_checks++; if (xm_sel_md !== 1'b0) begin n_fail++; $display("FAIL rst_xm_sel_md: got %b expected 0", xm_sel_md); end
        n_checks++; if (md_wb_rd !== 5'd0) begin n_fail++; $display("FAIL rst_md_wb_rd: got %0d expected 0", md_wb_rd); end
        n_checks++; if (md_exc !== 1'b0) begin n_fail++; $display("FAIL rst_md_exc: got %b expected 0", md_exc); end
        tick();
        tick();
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_hold_stall: got %b expected 0", stall); end
        rst_n = 1'b1;
    endtask

    // mul accepted on the first edge after reset, result at cycle 5, DONE at 6.
    task automatic test_mul();
        drive_op(ALU_OP_MUL, 5'd9);
        #1;
        n_checks++; if (ctrl_mult !== 1'b1) begin n_fail++; $display("FAIL mul_start c0: got %b expected 1", ctrl_mult); end
        n_checks++; if (ctrl_div !== 1'b0) begin n_fail++; $display("FAIL mul_no_div c0: got %b expected 0", ctrl_div); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mul_stall c0: got %b expected 1", stall); end
        n_checks++; if (xm_bubble !== 1'b1) begin n_fail++; $display("FAIL mul_bubble c0: got %b expected 1", xm_bubble); end
        tick();
        for (int c = 1; c <= 5; c++) begin
            md_result_rdy = (c == 5);
            #1;
            n_checks++; if (ctrl_mult !== 1'b0) begin n_fail++; $display("FAIL mul_pulse_once c%0d: got %b expected 0", c, ctrl_mult); end
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mul_stall c%0d: got %b expected 1", c, stall); end
            n_checks++; if (xm_sel_md !== 1'b0) begin n_fail++; $display("FAIL mul_sel_early c%0d: got %b expected 0", c, xm_sel_md); end
            tick();
        end
        md_result_rdy = 1'b0;
        #1;
        n_checks++; if (xm_sel_md !== 1'b1) begin n_fail++; $display("FAIL mul_done_sel c6: got %b expected 1", xm_sel_md); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mul_done_stall c6: got %b expected 0", stall); end
        n_checks++; if (ctrl_mult !== 1'b0) begin n_fail++; $display("FAIL mul_done_restart c6: got %b expected 0", ctrl_mult); end
        n_checks++; if (md_wb_rd !== 5'd9) begin n_fail++; $display("FAIL mul_wb_rd c6: got %0d expected 9", md_wb_rd); end
        n_checks++; if (md_exc !== 1'b0) begin n_fail++; $display("FAIL mul_exc c6: got %b expected 0", md_exc); end
        tick();
        set_idle();
        #1;
        n_checks++; if (xm_sel_md !== 1'b0) begin n_fail++; $display("FAIL mul_idle_sel c7: got %b expected 0", xm_sel_md); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mul_idle_stall c7: got %b expected 0", stall); end
        tick();
    endtask

    // div never answered: counter reaches 39 at cycle 40, DONE with exception at 41.
    task automatic test_timeout();
        drive_op(ALU_OP_DIV, 5'd17);
        #1;
        n_checks++; if (ctrl_div !== 1'b1) begin n_fail++; $display("FAIL to_start c0: got %b expected 1", ctrl_div); end
        n_checks++; if (ctrl_mult !== 1'b0) begin n_fail++; $display("FAIL to_no_mult c0: got %b expected 0", ctrl_mult); end
        tick();
        for (int c = 1; c <= 40; c++) begin
            #1;
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL to_stall c%0d: got %b expected 1", c, stall); end
            n_checks++; if (xm_sel_md !== 1'b0) begin n_fail++; $display("FAIL to_sel_early c%0d: got %b expected 0", c, xm_sel_md); end
            tick();
        end
        #1;
        n_checks++; if (xm_sel_md !== 1'b1) begin n_fail++; $display("FAIL to_done_sel c41: got %b expected 1", xm_sel_md); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_done_stall c41: got %b expected 0", stall); end
        n_checks++; if (md_exc !== 1'b1) begin n_fail++; $display("FAIL to_exc c41: got %b expected 1", md_exc); end
        n_checks++; if (md_wb_rd !== 5'd17) begin n_fail++; $display("FAIL to_wb_rd c41: got %0d expected 17", md_wb_rd); end
        tick();
        set_idle();
        #1;
        n_checks++; if (xm_sel_md !== 1'b0) begin n_fail++; $display("FAIL to_idle_sel c42: got %b expected 0", xm_sel_md); end
        tick();
    endtask

    // Result arrives on the terminal-count cycle: result wins, no exception.
    task automatic test_result_at_timeout();
        drive_op(ALU_OP_MUL, 5'd21);
        tick();
        for (int c = 1; c <= 40; c++) begin
            md_result_rdy = (c == 40);
            md_exception  = 1'b0;
            #1;
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL race_stall c%0d: got %b expected 1", c, stall); end
            tick();
        end
        md_result_rdy = 1'b0;
        #1;
        n_checks++; if (xm_sel_md !== 1'b1) begin n_fail++; $display("FAIL race_sel c41: got %b expected 1", xm_sel_md); end
        n_checks++; if (md_exc !== 1'b0) begin n_fail++; $display("FAIL race_exc c41: got %b expected 0", md_exc); end
        tick();
        set_idle();
        tick();
    endtask

    // Abort in IDLE suppresses start; abort at BUSY cycle 3 returns to IDLE at 4.
    task automatic test_abort();
        drive_op(ALU_OP_MUL, 5'd11);
        abort = 1'b1;
        #1;
        n_checks++; if (ctrl_mult !== 1'b0) begin n_fail++; $display("FAIL abort_idle_pulse: got %b expected 0", ctrl_mult); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL abort_idle_stall: got %b expected 0", stall); end
        tick();
        abort = 1'b0;
        #1;
        n_checks++; if (ctrl_mult !== 1'b1) begin n_fail++; $display("FAIL abort_start c0: got %b expected 1", ctrl_mult); end
        tick();
        for (int c = 1; c <= 3; c++) begin
            abort = (c == 3);
            #1;
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL abort_busy_stall c%0d: got %b expected 1", c, stall); end
            tick();
        end
        set_idle();
        md_result_rdy = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall_drop c4: got %b expected 0", stall); end
        n_checks++; if (xm_sel_md !== 1'b0) begin n_fail++; $display("FAIL abort_sel c4: got %b expected 0", xm_sel_md); end
        n_checks++; if (md_exc !== 1'b0) begin n_fail++; $display("FAIL abort_exc c4: got %b expected 0", md_exc); end
        tick();
        md_result_rdy = 1'b0;
        #1;
        n_checks++; if (xm_sel_md !== 1'b0) begin n_fail++; $display("FAIL abort_stray_rdy c5: got %b expected 0", xm_sel_md); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL abort_idle c5: got %b expected 0", stall); end
        tick();
    endtask

    // mul then div back to back; abort during DONE is ignored.
    task automatic test_back_to_back();
        drive_op(ALU_OP_MUL, 5'd3);
        #1;
        n_checks++; if (ctrl_mult !== 1'b1) begin n_fail++; $display("FAIL b2b_mul_pulse c0: got %b expected 1", ctrl_mult); end
        n_checks++; if (ctrl_div !== 1'b0) begin n_fail++; $display("FAIL b2b_mul_nodiv c0: got %b expected 0", ctrl_div); end
        tick();
        for (int c = 1; c <= 2; c++) begin
            md_result_rdy = (c == 2);
            #1;
            n_checks++; if ((ctrl_mult | ctrl_div) !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_busy c%0d: got %b expected 0", c, ctrl_mult | ctrl_div); end
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall c%0d: got %b expected 1", c, stall); end
            tick();
        end
        md_result_rdy = 1'b0;
        abort = 1'b1;
        #1;
        n_checks++; if (xm_sel_md !== 1'b1) begin n_fail++; $display("FAIL b2b_done1_sel c3: got %b expected 1", xm_sel_md); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done1_stall c3: got %b expected 0", stall); end
        n_checks++; if (ctrl_mult !== 1'b0) begin n_fail++; $display("FAIL b2b_done1_dup c3: got %b expected 0", ctrl_mult); end
        n_checks++; if (md_wb_rd !== 5'd3) begin n_fail++; $display("FAIL b2b_done1_rd c3: got %0d expected 3", md_wb_rd); end
        tick();
        abort = 1'b0;
        drive_op(ALU_OP_DIV, 5'd4);
        #1;
        n_checks++; if (ctrl_div !== 1'b1) begin n_fail++; $display("FAIL b2b_div_pulse c4: got %b expected 1", ctrl_div); end
        n_checks++; if (ctrl_mult !== 1'b0) begin n_fail++; $display("FAIL b2b_div_nomult c4: got %b expected 0", ctrl_mult); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_div_stall c4: got %b expected 1", stall); end
        n_checks++; if (xm_sel_md !== 1'b0) begin n_fail++; $display("FAIL b2b_div_sel c4: got %b expected 0", xm_sel_md); end
        tick();
        md_result_rdy = 1'b1;
        md_exception  = 1'b1;
        #1;
        n_checks++; if (ctrl_div !== 1'b0) begin n_fail++; $display("FAIL b2b_div_once c5: got %b expected 0", ctrl_div); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_div_busy c5: got %b expected 1", stall); end
        tick();
        md_result_rdy = 1'b0;
        md_exception  = 1'b0;
        #1;
        n_checks++; if (xm_sel_md !== 1'b1) begin n_fail++; $display("FAIL b2b_done2_sel c6: got %b expected 1", xm_sel_md); end
        n_checks++; if (md_wb_rd !== 5'd4) begin n_fail++; $display("FAIL b2b_done2_rd c6: got %0d expected 4", md_wb_rd); end
        n_checks++; if (md_exc !== 1'b1) begin n_fail++; $display("FAIL b2b_done2_exc c6: got %b expected 1", md_exc); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_done2_stall c6: got %b expected 0", stall); end
        tick();
        set_idle();
        #1;
        n_checks++; if (xm_sel_md !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_sel c7: got %b expected 0", xm_sel_md); end
        tick();
    endtask

    // Instructions that must not start the unit.
    task automatic test_no_start();
        drive_op(ALU_OP_MUL, 5'd5);
        dx_is_rtype = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL nostart_non_rtype: got %b expected 0", stall); end
        tick();
        drive_op(ALU_OP_DIV, 5'd5);
        dx_valid = 1'b0;
        #1;
        n_checks++; if (ctrl_div !== 1'b0) begin n_fail++; $display("FAIL nostart_bubble: got %b expected 0", ctrl_div); end
        tick();
        drive_op(5'b00000, 5'd5);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL nostart_add: got %b expected 0", stall); end
        tick();
        set_idle();
    endtask

    // Reset mid-BUSY clears everything at once; stray result afterwards is ignored.
    task automatic test_reset_busy();
        drive_op(ALU_OP_MUL, 5'd13);
        tick();
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rb_busy_stall: got %b expected 1", stall); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rb_stall: got %b expected 0", stall); end
        n_checks++; if (xm_bubble !== 1'b0) begin n_fail++; $display("FAIL rb_bubble: got %b expected 0", xm_bubble); end
        n_checks++; if ((ctrl_mult | ctrl_div) !== 1'b0) begin n_fail++; $display("FAIL rb_pulse: got %b expected 0", ctrl_mult | ctrl_div); end
        n_checks++; if (xm_sel_md !== 1'b0) begin n_fail++; $display("FAIL rb_sel: got %b expected 0", xm_sel_md); end
        n_checks++; if (md_wb_rd !== 5'd0) begin n_fail++; $display("FAIL rb_wb_rd: got %0d expected 0", md_wb_rd); end
        n_checks++; if (md_exc !== 1'b0) begin n_fail++; $display("FAIL rb_exc: got %b expected 0", md_exc); end
        tick();
        rst_n = 1'b1;
        drive_op(5'b00000, 5'd2);
        md_result_rdy = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rb_after_stall: got %b expected 0", stall); end
        tick();
        md_result_rdy = 1'b0;
        #1;
        n_checks++; if (xm_sel_md !== 1'b0) begin n_fail++; $display("FAIL rb_after_sel: got %b expected 0", xm_sel_md); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rb_after_idle: got %b expected 0", stall); end
        tick();
        set_idle();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_timeout();
        test_result_at_timeout();
        test_abort();
        test_back_to_back();
        test_no_start();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 40: max BUSY cycles before a forced timeout exception.
REQ-002 Parameter CNT_W, default 6: cycle-counter width; must satisfy 2^CNT_W > TIMEOUT.
REQ-003 clock  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 dx_valid  in  1  DX latch holds a live (non-bubble) instruction.
REQ-006 dx_alu_op  in  5  ALU op field of DX instruction; 00110 = mul, 00111 = div.
REQ-007 dx_is_rtype  in  1  DX opcode is R-type (00000).
REQ-008 dx_rd  in  5  destination register of DX instruction.
REQ-009 abort  in  1  kill in-flight operation (exception/interrupt from later stage).
REQ-010 md_result_rdy  in  1  multdiv unit result valid this cycle.
REQ-011 md_exception  in  1  multdiv unit overflow/div-by-zero, valid with md_result_rdy.
REQ-012 ctrl_mult  out  1  one-cycle start pulse to multdiv unit for mul.
REQ-013 ctrl_div  out  1  one-cycle start pulse to multdiv unit for div.
REQ-014 stall  out  1  freeze PC, FD and DX latches.
REQ-015 xm_bubble  out  1  load nop into XM latch this cycle.
REQ-016 xm_sel_md  out  1  XM input mux selects multdiv result instead of ALU output.
REQ-017 md_wb_rd  out  5  destination register latched at start.
REQ-018 md_exc  out  1  exception flag for writeback (unit exception or timeout).

Function
REQ-019 Start condition: IDLE & dx_valid & dx_is_rtype & dx_alu_op in {00110,00111} & ~abort.
REQ-020 States: IDLE, BUSY, DONE; encoding from package.
REQ-021 IDLE: on start condition, pulse ctrl_mult or ctrl_div (matching op) for exactly that cycle, latch dx_rd into md_wb_rd, clear counter, go BUSY.
REQ-022 stall is combinational: 1 when (IDLE & start condition) or BUSY; 0 in DONE and otherwise.
REQ-023 xm_bubble equals stall, so no duplicate instruction reaches XM during the operation.
REQ-024 BUSY: counter increments each cycle; md_result_rdy=1 -> go DONE, md_exc latches md_exception.
REQ-025 BUSY: counter == TIMEOUT-1 with md_result_rdy=0 -> go DONE, md_exc latches 1.
REQ-026 Result-ready and timeout in the same cycle: result wins; md_exc = md_exception.
REQ-027 DONE lasts exactly one cycle: xm_sel_md=1, stall=0, DX advances into XM; then go IDLE.
REQ-028 Start is evaluated only in IDLE; a mul/div arriving in DX immediately after DONE starts the cycle after DONE (back-to-back supported, no lost instruction).
REQ-029 abort in BUSY: go IDLE next cycle, no DONE, xm_sel_md never asserted, md_exc cleared; stall drops the cycle after abort.
REQ-030 abort in IDLE suppresses start; abort in DONE is ignored (instruction has already committed to XM).
REQ-031 md_result_rdy outside BUSY is ignored.
REQ-032 ctrl_mult and ctrl_div are never asserted together or for more than one cycle per operation.

Reset
REQ-033 reset low, asynchronously: state=IDLE, counter=0, md_wb_rd=0, md_exc=0, all pulse/stall/select outputs 0.
REQ-034 Reset asserted mid-BUSY abandons the operation; no writeback select after release.
REQ-035 First start is accepted on the first rising edge after reset deasserts.

Structure
REQ-036 Package multdiv_ctrl_pkg holds state encoding, ALU_OP_MUL=00110, ALU_OP_DIV=00111, OPC_RTYPE=00000, and default TIMEOUT.
REQ-037 One sub-module md_cycle_counter (CNT_W-bit, sync clear, enable, terminal-count output at TIMEOUT-1).
REQ-038 Block sits beside the execute stage; it does not instantiate the multdiv unit or pipeline latches.

Verification
REQ-039 mul in DX at cycle 0, md_result_rdy at cycle 5 -> ctrl_mult=1 only at cycle 0, stall=1 cycles 0-5, xm_sel_md=1 at cycle 6, md_wb_rd=dx_rd.
REQ-040 div with md_result_rdy never asserted, TIMEOUT=40 -> DONE at cycle 41, md_exc=1, stall drops at cycle 41.
REQ-041 md_result_rdy=1 with md_exception=0 on the cycle counter hits TIMEOUT-1 -> md_exc=0.
REQ-042 abort at cycle 3 of BUSY -> IDLE at cycle 4, xm_sel_md stays 0, stall=0 from cycle 4.
REQ-043 mul immediately followed by div in DX -> two distinct start pulses, two DONE cycles, no instruction dropped or duplicated in XM.
REQ-044 reset pulled low during BUSY -> all outputs 0 immediately; after release, non-mul instruction in DX -> stall=0.
